// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RV32I pipeline register bank.
// Holds the IF/ID and ID/EX bundle layouts and the ID/EX bubble value.
package riscv_pipe_pkg;

    localparam int XLEN        = 32;
    localparam int REG_W       = 5;
    localparam int RESULTSRC_W = 2;
    localparam int ALUCTRL_W   = 3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    typedef struct packed {
        logic                   reg_write;
        logic [RESULTSRC_W-1:0] result_src;
        logic                   mem_write;
        logic                   jump;
        logic                   branch;
        logic [ALUCTRL_W-1:0]   alu_control;
        logic                   alu_src;
        logic [XLEN-1:0]        rd1;
        logic [XLEN-1:0]        rd2;
        logic [XLEN-1:0]        imm_ext;
        logic [XLEN-1:0]        pc;
        logic [XLEN-1:0]        pc_plus4;
        logic [REG_W-1:0]       rs1;
        logic [REG_W-1:0]       rs2;
        logic [REG_W-1:0]       rd;
        logic                   valid;
    } id_ex_t;

    // All-zero bundle: no register write, no memory write, no branch or
    // jump and rd=x0, so it can never trigger forwarding or a load-use stall.
    localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/pipe_flop_ensc.sv
// Generic pipeline flop with sync reset, sync clear and enable.
// Clear loads the same value as reset and takes priority over enable.
module pipe_flop_ensc #(
    parameter int           W    = 1,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset beats clear, clear beats enable, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= INIT;
        end else if (clr) begin
            q <= INIT;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_regs_fde.sv
// Fetch/decode/execute register bank driven by the hazard unit requests.
// Also keeps saturating stall/flush counters and a sticky protocol-error flag.
import riscv_pipe_pkg::*;

module pipe_regs_fde #(
    parameter int              XLEN      = riscv_pipe_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = riscv_pipe_pkg::NOP_INSTR,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             FlushE,
    input  logic [XLEN-1:0]  PCNextF,
    output logic [XLEN-1:0]  PCF,
    input  logic [31:0]      InstrF,
    input  logic [XLEN-1:0]  PCPlus4F,
    output logic [31:0]      InstrD,
    output logic [XLEN-1:0]  PCD,
    output logic [XLEN-1:0]  PCPlus4D,
    output logic             ValidD,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic [1:0]       ResultSrcD,
    input  logic [2:0]       ALUControlD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [XLEN-1:0]  PCD_in,
    input  logic [XLEN-1:0]  PCPlus4D_in,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             JumpE,
    output logic             BranchE,
    output logic             ALUSrcE,
    output logic [1:0]       ResultSrcE,
    output logic [2:0]       ALUControlE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic             ValidE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             proto_err
);

    localparam if_id_t IF_ID_INIT = '{
        instr:    NOP_INSTR,
        pc:       '0,
        pc_plus4: '0,
        valid:    1'b0
    };

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if_id_t if_id_d;
    if_id_t if_id_q;
    id_ex_t id_ex_d;
    id_ex_t id_ex_q;

    logic stall_ev;
    logic flush_ev;
    logic proto_ev;

    pipe_flop_ensc #(
        .W    (XLEN),
        .INIT (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .en    (~StallF),
        .clr   (1'b0),
        .d     (PCNextF),
        .q     (PCF)
    );

    // Fetch-side bundle captured into IF/ID.
    always_comb begin
        if_id_d          = IF_ID_INIT;
        if_id_d.instr    = InstrF;
        if_id_d.pc       = PCF;
        if_id_d.pc_plus4 = PCPlus4F;
        if_id_d.valid    = 1'b1;
    end

    pipe_flop_ensc #(
        .W    ($bits(if_id_t)),
        .INIT (IF_ID_INIT)
    ) u_if_id (
        .clk   (clk),
        .reset (reset),
        .en    (~StallD),
        .clr   (FlushD),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign InstrD   = if_id_q.instr;
    assign PCD      = if_id_q.pc;
    assign PCPlus4D = if_id_q.pc_plus4;
    assign ValidD   = if_id_q.valid;

    // Decode-side bundle captured into ID/EX; validity follows IF/ID.
    always_comb begin
        id_ex_d             = ID_EX_BUBBLE;
        id_ex_d.reg_write   = RegWriteD;
        id_ex_d.result_src  = ResultSrcD;
        id_ex_d.mem_write   = MemWriteD;
        id_ex_d.jump        = JumpD;
        id_ex_d.branch      = BranchD;
        id_ex_d.alu_control = ALUControlD;
        id_ex_d.alu_src     = ALUSrcD;
        id_ex_d.rd1         = RD1D;
        id_ex_d.rd2         = RD2D;
        id_ex_d.imm_ext     = ImmExtD;
        id_ex_d.pc          = PCD_in;
        id_ex_d.pc_plus4    = PCPlus4D_in;
        id_ex_d.rs1         = Rs1D;
        id_ex_d.rs2         = Rs2D;
        id_ex_d.rd          = RdD;
        id_ex_d.valid       = ValidD;
    end

    pipe_flop_ensc #(
        .W    ($bits(id_ex_t)),
        .INIT (ID_EX_BUBBLE)
    ) u_id_ex (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (FlushE),
        .d     (id_ex_d),
        .q     (id_ex_q)
    );

    assign RegWriteE   = id_ex_q.reg_write;
    assign ResultSrcE  = id_ex_q.result_src;
    assign MemWriteE   = id_ex_q.mem_write;
    assign JumpE       = id_ex_q.jump;
    assign BranchE     = id_ex_q.branch;
    assign ALUControlE = id_ex_q.alu_control;
    assign ALUSrcE     = id_ex_q.alu_src;
    assign RD1E        = id_ex_q.rd1;
    assign RD2E        = id_ex_q.rd2;
    assign ImmExtE     = id_ex_q.imm_ext;
    assign PCE         = id_ex_q.pc;
    assign PCPlus4E    = id_ex_q.pc_plus4;
    assign Rs1E        = id_ex_q.rs1;
    assign Rs2E        = id_ex_q.rs2;
    assign RdE         = id_ex_q.rd;
    assign ValidE      = id_ex_q.valid;

    // A flush overrides a stall, so only a real hold counts as a stall.
    assign stall_ev = StallD & ~FlushD;
    assign flush_ev = FlushD;
    assign proto_ev = StallD & ~StallF;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_ev && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_ev && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    // Sticky flag: decode held while fetch advanced drops an instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (proto_ev) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_regs_fde.sv
// Directed bench for pipe_regs_fde: a table of per-edge vectors plus
// hand-written saturation and reset-during-stall sequences.
module tb_pipe_regs_fde;

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, FlushE;
    logic [31:0] PCNextF, PCF, InstrF, PCPlus4F;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD_in, PCPlus4D_in;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        ValidE;
    logic [3:0]  stall_cnt, flush_cnt;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign PCPlus4F    = PCF + 32'd4;
    assign PCD_in      = PCD;
    assign PCPlus4D_in = PCPlus4D;

    pipe_regs_fde #(
        .XLEN      (32),
        .RESET_PC  (32'h0),
        .NOP_INSTR (32'h0000_0013),
        .CNT_W     (4)
    ) dut (
        .clk(clk), .reset(reset),
        .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE),
        .PCNextF(PCNextF), .PCF(PCF),
        .InstrF(InstrF), .PCPlus4F(PCPlus4F),
        .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
        .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .PCD_in(PCD_in), .PCPlus4D_in(PCPlus4D_in),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ValidE(ValidE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .proto_err(proto_err)
    );

    typedef struct {
        logic        rst, sf, sd, fd, fe;
        logic [31:0] pcn, instr;
        logic [4:0]  rdd;
        logic        rwd;
        logic [31:0] x_pcf, x_instrd, x_pcd;
        logic        x_vd, x_ve;
        logic [4:0]  x_rde;
        logic        x_rwe;
        logic [3:0]  x_sc, x_fc;
        logic        x_pe;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(
        input logic rst, sf, sd, fd, fe,
        input logic [31:0] pcn, instr,
        input logic [4:0] rdd, input logic rwd,
        input logic [31:0] x_pcf, x_instrd, x_pcd,
        input logic x_vd, x_ve,
        input logic [4:0] x_rde, input logic x_rwe,
        input logic [3:0] x_sc, x_fc, input logic x_pe
    );
        vec_t v;
        v.rst = rst; v.sf = sf; v.sd = sd; v.fd = fd; v.fe = fe;
        v.pcn = pcn; v.instr = instr; v.rdd = rdd; v.rwd = rwd;
        v.x_pcf = x_pcf; v.x_instrd = x_instrd; v.x_pcd = x_pcd;
        v.x_vd = x_vd; v.x_ve = x_ve; v.x_rde = x_rde; v.x_rwe = x_rwe;
        v.x_sc = x_sc; v.x_fc = x_fc; v.x_pe = x_pe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_decode(input int i, input logic [4:0] rdd, input logic rwd);
        RdD         = rdd;
        RegWriteD   = rwd;
        RD1D        = 32'h1000_0000 + i;
        RD2D        = 32'h2000_0000 + 3 * i;
        ImmExtD     = 32'h0000_0100 + 7 * i;
        Rs1D        = 5'(i + 3);
        Rs2D        = 5'(i + 9);
        ResultSrcD  = 2'(i);
        ALUControlD = 3'(i + 1);
        ALUSrcD     = i[0];
        MemWriteD   = i[1];
        JumpD       = i[2];
        BranchD     = i[3];
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pcf"}, 64'(PCF), 64'h0);
        chk({tag, "_instrd"}, 64'(InstrD), 64'h13);
        chk({tag, "_pcd"}, 64'(PCD), 64'h0);
        chk({tag, "_pcplus4d"}, 64'(PCPlus4D), 64'h0);
        chk({tag, "_validd"}, 64'(ValidD), 64'h0);
        chk({tag, "_valide"}, 64'(ValidE), 64'h0);
        chk({tag, "_e_data"}, 64'(RD1E | RD2E | ImmExtE | PCE | PCPlus4E), 64'h0);
        chk({tag, "_e_ctrl"}, 64'({RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
                                   ResultSrcE, ALUControlE, Rs1E, Rs2E, RdE}), 64'h0);
        chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'h0);
        chk({tag, "_flush_cnt"}, 64'(flush_cnt), 64'h0);
        chk({tag, "_proto_err"}, 64'(proto_err), 64'h0);
    endtask

    initial begin
        logic [31:0] prev_pcd, prev_pcp4d, x_pcp4d;
        logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_pcp4;
        logic [15:0] e_ctl, a_ctl;
        logic [3:0]  sc_model;
        vec_t v;

        vecs[0]  = mk(1,0,0,0,0, 32'h0,  32'h00500093, 0,0, 32'h0,  32'h13,       32'h0,  0,0, 0,0, 0,0,0);
        vecs[1]  = mk(1,0,0,0,0, 32'h0,  32'h00500093, 0,0, 32'h0,  32'h13,       32'h0,  0,0, 0,0, 0,0,0);
        vecs[2]  = mk(0,0,0,0,0, 32'h4,  32'h00500093, 0,0, 32'h4,  32'h00500093, 32'h0,  1,0, 0,0, 0,0,0);
        vecs[3]  = mk(0,0,0,0,0, 32'h8,  32'h00A00113, 1,1, 32'h8,  32'h00A00113, 32'h4,  1,1, 1,1, 0,0,0);
        vecs[4]  = mk(0,1,1,0,1, 32'hC,  32'h002081B3, 2,1, 32'h8,  32'h00A00113, 32'h4,  1,0, 0,0, 1,0,0);
        vecs[5]  = mk(0,0,0,0,0, 32'hC,  32'h002081B3, 2,1, 32'hC,  32'h002081B3, 32'h8,  1,1, 2,1, 1,0,0);
        vecs[6]  = mk(0,0,0,1,1, 32'h40, 32'h00000463, 3,1, 32'h40, 32'h13,       32'h0,  0,0, 0,0, 1,1,0);
        vecs[7]  = mk(0,0,0,0,0, 32'h44, 32'h00100213, 0,0, 32'h44, 32'h00100213, 32'h40, 1,0, 0,0, 1,1,0);
        vecs[8]  = mk(0,1,1,1,0, 32'h48, 32'h00200293, 4,1, 32'h44, 32'h13,       32'h0,  0,1, 4,1, 1,2,0);
        vecs[9]  = mk(0,0,1,0,0, 32'h48, 32'h00200293, 0,0, 32'h48, 32'h13,       32'h0,  0,0, 0,0, 2,2,1);
        vecs[10] = mk(0,0,0,0,0, 32'h4C, 32'h00300293, 0,0, 32'h4C, 32'h00300293, 32'h48, 1,0, 0,0, 2,2,1);

        prev_pcd   = 32'h0;
        prev_pcp4d = 32'h0;

        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            reset = v.rst; StallF = v.sf; StallD = v.sd;
            FlushD = v.fd; FlushE = v.fe;
            PCNextF = v.pcn; InstrF = v.instr;
            drive_decode(i, v.rdd, v.rwd);

            if (v.rst || v.fe) begin
                e_rd1 = 0; e_rd2 = 0; e_imm = 0; e_pc = 0; e_pcp4 = 0; e_ctl = 0;
            end else begin
                e_rd1  = RD1D;
                e_rd2  = RD2D;
                e_imm  = ImmExtD;
                e_pc   = prev_pcd;
                e_pcp4 = prev_pcp4d;
                e_ctl  = {MemWriteD, JumpD, BranchD, ALUSrcD,
                          ResultSrcD, ALUControlD, Rs1D, Rs2D};
            end

            @(posedge clk);
            @(negedge clk);

            x_pcp4d = v.x_vd ? v.x_pcd + 32'd4 : 32'h0;
            a_ctl   = {MemWriteE, JumpE, BranchE, ALUSrcE,
                       ResultSrcE, ALUControlE, Rs1E, Rs2E};

            chk($sformatf("v%0d_pcf", i), 64'(PCF), 64'(v.x_pcf));
            chk($sformatf("v%0d_instrd", i), 64'(InstrD), 64'(v.x_instrd));
            chk($sformatf("v%0d_pcd", i), 64'(PCD), 64'(v.x_pcd));
            chk($sformatf("v%0d_pcplus4d", i), 64'(PCPlus4D), 64'(x_pcp4d));
            chk($sformatf("v%0d_validd", i), 64'(ValidD), 64'(v.x_vd));
            chk($sformatf("v%0d_valide", i), 64'(ValidE), 64'(v.x_ve));
            chk($sformatf("v%0d_rde", i), 64'(RdE), 64'(v.x_rde));
            chk($sformatf("v%0d_regwritee", i), 64'(RegWriteE), 64'(v.x_rwe));
            chk($sformatf("v%0d_rd1e", i), 64'(RD1E), 64'(e_rd1));
            chk($sformatf("v%0d_rd2e", i), 64'(RD2E), 64'(e_rd2));
            chk($sformatf("v%0d_immexte", i), 64'(ImmExtE), 64'(e_imm));
            chk($sformatf("v%0d_pce", i), 64'(PCE), 64'(e_pc));
            chk($sformatf("v%0d_pcplus4e", i), 64'(PCPlus4E), 64'(e_pcp4));
            chk($sformatf("v%0d_e_ctrl", i), 64'(a_ctl), 64'(e_ctl));
            chk($sformatf("v%0d_stall_cnt", i), 64'(stall_cnt), 64'(v.x_sc));
            chk($sformatf("v%0d_flush_cnt", i), 64'(flush_cnt), 64'(v.x_fc));
            chk($sformatf("v%0d_proto_err", i), 64'(proto_err), 64'(v.x_pe));

            prev_pcd   = v.x_pcd;
            prev_pcp4d = x_pcp4d;
        end

        // Hold a legal stall long enough to saturate the 4-bit counter.
        sc_model = 4'd2;
        reset = 0; StallF = 1; StallD = 1; FlushD = 0; FlushE = 0;
        PCNextF = 32'h50; InstrF = 32'h00400313;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (sc_model != 4'hF) sc_model = sc_model + 4'd1;
            chk($sformatf("sat%0d_stall_cnt", c), 64'(stall_cnt), 64'(sc_model));
        end
        chk("sat_pcf_held", 64'(PCF), 64'h4C);
        chk("sat_instrd_held", 64'(InstrD), 64'h00300293);
        chk("sat_stall_cnt_final", 64'(stall_cnt), 64'hF);
        chk("sat_proto_err_sticky", 64'(proto_err), 64'h1);

        // Reset arriving mid-stall (with flush requests too) must win outright.
        reset = 1; FlushD = 1; FlushE = 0;
        drive_decode(21, 5'd7, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_reset_state("rst_in_stall");

        // First free-running edge after reset.
        reset = 0; StallF = 0; StallD = 0; FlushD = 0; FlushE = 0;
        PCNextF = 32'h4; InstrF = 32'h00700393;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_pcf", 64'(PCF), 64'h4);
        chk("post_rst_instrd", 64'(InstrD), 64'h00700393);
        chk("post_rst_validd", 64'(ValidD), 64'h1);
        chk("post_rst_valide", 64'(ValidE), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
